// File: rtl/pong_frame_renderer_pkg.sv
// rtl/pong_frame_renderer_pkg.sv - Pong renderer geometry, colours, reset positions and span-hit helper
package pong_frame_renderer_pkg;

    localparam int H         = 120;
    localparam int W         = 160;
    localparam int BLOCK     = 4;
    localparam int BALL_SIZE = 4;
    localparam int PADDLE_W  = 1;
    localparam int PADDLE_H  = 32;
    localparam int V_ACTIVE  = 480;

    localparam logic [11:0] COL_BG     = 12'h000;
    localparam logic [11:0] COL_BALL   = 12'hFFF;
    localparam logic [11:0] COL_PLAYER = 12'h0F0;
    localparam logic [11:0] COL_COM    = 12'hF00;
    localparam logic [11:0] COL_NET    = 12'h888;
    localparam logic [11:0] COL_DIGIT  = 12'hFFF;

    localparam logic [7:0] BALL_X_RST   = 8'd80;
    localparam logic [6:0] BALL_Y_RST   = 7'd60;
    localparam logic [7:0] PLAYER_X_RST = 8'd3;
    localparam logic [7:0] COM_X_RST    = 8'd156;

    localparam int DIGIT_ROW        = 4;
    localparam int DIGIT_H          = 5;
    localparam int DIGIT_W          = 3;
    localparam int PLAYER_DIGIT_COL = 64;
    localparam int COM_DIGIT_COL    = 93;
    localparam int WIN_SCORE        = 10;

    // True when pos lies in [start, start+size); the sum is one bit wider so it never wraps
    function automatic logic spanHit(input logic [7:0] pos, input logic [7:0] start,
                                     input logic [7:0] size);
        logic [8:0] endExcl;
        endExcl = {1'b0, start} + {1'b0, size};
        return (pos >= start) && ({1'b0, pos} < endExcl);
    endfunction

endpackage

// File: rtl/pong_frame_renderer_if.sv
// rtl/pong_frame_renderer_if.sv - game-state bus between Pong game logic and the renderer
interface pong_frame_renderer_if;
    logic [7:0] ballX_in;
    logic [6:0] ballY_in;
    logic [7:0] playerXPos_in;
    logic [6:0] playerYPos_in;
    logic [7:0] comXPos_in;
    logic [6:0] comYPos_in;
    logic [3:0] playerScore_in;
    logic [3:0] comScore_in;
    logic       frame_tick;

    modport master (
        output ballX_in, ballY_in, playerXPos_in, playerYPos_in,
               comXPos_in, comYPos_in, playerScore_in, comScore_in,
        input  frame_tick
    );

    modport slave (
        input  ballX_in, ballY_in, playerXPos_in, playerYPos_in,
               comXPos_in, comYPos_in, playerScore_in, comScore_in,
        output frame_tick
    );
endinterface

// File: rtl/score_glyph_rom.sv
// rtl/score_glyph_rom.sv - 3x5 score digit glyphs; 10..15 give a solid win block
module score_glyph_rom (
    input  logic [3:0] digit,
    input  logic [2:0] row,
    input  logic [1:0] col,
    output logic       pixel
);
    logic [14:0] glyph;
    logic [3:0]  bitIdx;

    // Glyph rows packed top row first, leftmost column in the MSB of each 3-bit row
    always_comb begin
        glyph  = 15'b111_111_111_111_111;
        bitIdx = 4'(row) * 4'd3 + 4'(col);
        case (digit)
            4'd0: glyph = 15'b111_101_101_101_111;
            4'd1: glyph = 15'b010_110_010_010_111;
            4'd2: glyph = 15'b111_001_111_100_111;
            4'd3: glyph = 15'b111_001_111_001_111;
            4'd4: glyph = 15'b101_101_111_001_001;
            4'd5: glyph = 15'b111_100_111_001_111;
            4'd6: glyph = 15'b111_100_111_101_111;
            4'd7: glyph = 15'b111_001_001_001_001;
            4'd8: glyph = 15'b111_101_111_101_111;
            4'd9: glyph = 15'b111_101_111_001_111;
            default: glyph = 15'b111_111_111_111_111;
        endcase
        pixel = (row <= 3'd4 && col <= 2'd2) ? glyph[4'd14 - bitIdx] : 1'b0;
    end
endmodule

// File: rtl/pong_frame_renderer.sv
// rtl/pong_frame_renderer.sv - Pong pixel renderer, 2-cycle pipeline; SCORE_DISPLAY_EN adds score digits
module pong_frame_renderer
    import pong_frame_renderer_pkg::*;
(
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    pong_frame_renderer_if.slave gameBus,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);
    logic [7:0] gx;
    logic [6:0] gy;
    logic       unusedRasterBits;
    logic       frameStart;

    assign gx = hcount[9:2];
    assign gy = vcount[8:2];
    assign unusedRasterBits = ^{hcount[1:0], vcount[1:0], vcount[9]};
    assign frameStart = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
    assign gameBus.frame_tick = frameStart && !reset;

    logic [7:0] snapBallX, snapPlayerX, snapComX;
    logic [6:0] snapBallY, snapPlayerY, snapComY;

    // Capture the whole game state on the frame tick so one frame never mixes two states
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            snapBallX   <= BALL_X_RST;
            snapBallY   <= BALL_Y_RST;
            snapPlayerX <= PLAYER_X_RST;
            snapPlayerY <= 7'd0;
            snapComX    <= COM_X_RST;
            snapComY    <= 7'd0;
        end else if (frameStart) begin
            snapBallX   <= gameBus.ballX_in;
            snapBallY   <= gameBus.ballY_in;
            snapPlayerX <= gameBus.playerXPos_in;
            snapPlayerY <= gameBus.playerYPos_in;
            snapComX    <= gameBus.comXPos_in;
            snapComY    <= gameBus.comYPos_in;
        end
    end

    logic gameOver;
    logic digitHit;

`ifdef SCORE_DISPLAY_EN
    logic [3:0] snapPlayerScore, snapComScore;
    logic       inPlayerDigit, inComDigit, playerPixel, comPixel;
    logic [2:0] glyphRow;

    // Scores share the once-per-frame capture with the positions
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            snapPlayerScore <= 4'd0;
            snapComScore    <= 4'd0;
        end else if (frameStart) begin
            snapPlayerScore <= gameBus.playerScore_in;
            snapComScore    <= gameBus.comScore_in;
        end
    end

    assign gameOver = (snapPlayerScore == 4'(WIN_SCORE)) || (snapComScore == 4'(WIN_SCORE));
    assign inPlayerDigit = spanHit(gx, 8'(PLAYER_DIGIT_COL), 8'(DIGIT_W))
                        && spanHit({1'b0, gy}, 8'(DIGIT_ROW), 8'(DIGIT_H));
    assign inComDigit = spanHit(gx, 8'(COM_DIGIT_COL), 8'(DIGIT_W))
                     && spanHit({1'b0, gy}, 8'(DIGIT_ROW), 8'(DIGIT_H));
    // Low bits suffice: the digit boxes are only 5 rows and 3 columns wide
    assign glyphRow = gy[2:0] - 3'(DIGIT_ROW);

    score_glyph_rom playerGlyph (
        .digit (snapPlayerScore),
        .row   (glyphRow),
        .col   (gx[1:0] - 2'(PLAYER_DIGIT_COL)),
        .pixel (playerPixel)
    );

    score_glyph_rom comGlyph (
        .digit (snapComScore),
        .row   (glyphRow),
        .col   (gx[1:0] - 2'(COM_DIGIT_COL)),
        .pixel (comPixel)
    );

    assign digitHit = (inPlayerDigit && playerPixel) || (inComDigit && comPixel);
`else
    logic unusedScoreBits;
    assign unusedScoreBits = ^{gameBus.playerScore_in, gameBus.comScore_in};
    assign gameOver = 1'b0;
    assign digitHit = 1'b0;
`endif

    logic ballHit, playerHit, comHit, netHit;

    assign ballHit = !gameOver
                  && spanHit(gx, snapBallX, 8'(BALL_SIZE))
                  && spanHit({1'b0, gy}, {1'b0, snapBallY}, 8'(BALL_SIZE));
    assign playerHit = spanHit(gx, snapPlayerX, 8'(PADDLE_W))
                    && spanHit({1'b0, gy}, {1'b0, snapPlayerY}, 8'(PADDLE_H));
    assign comHit = spanHit(gx, snapComX, 8'(PADDLE_W))
                 && spanHit({1'b0, gy}, {1'b0, snapComY}, 8'(PADDLE_H));
    assign netHit = (gx == 8'(W / 2)) && !gy[2];

    logic videoOnS1, ballHitS1, playerHitS1, comHitS1, digitHitS1, netHitS1;
    logic hsyncS1, vsyncS1;

    // Stage 1: register the per-layer hit flags and the active-video flag
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            videoOnS1   <= 1'b0;
            ballHitS1   <= 1'b0;
            playerHitS1 <= 1'b0;
            comHitS1    <= 1'b0;
            digitHitS1  <= 1'b0;
            netHitS1    <= 1'b0;
        end else begin
            videoOnS1   <= video_on;
            ballHitS1   <= ballHit;
            playerHitS1 <= playerHit;
            comHitS1    <= comHit;
            digitHitS1  <= digitHit;
            netHitS1    <= netHit;
        end
    end

    // Stage 2: resolve layer priority into the registered colour, black outside active video
    always_ff @(posedge VGA_CLK) begin
        if (reset || !videoOnS1)  rgb <= COL_BG;
        else if (ballHitS1)       rgb <= COL_BALL;
        else if (playerHitS1)     rgb <= COL_PLAYER;
        else if (comHitS1)        rgb <= COL_COM;
        else if (digitHitS1)      rgb <= COL_DIGIT;
        else if (netHitS1)        rgb <= COL_NET;
        else                      rgb <= COL_BG;
    end

    // Delay the syncs through two stages so they line up with rgb
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            hsyncS1   <= 1'b0;
            vsyncS1   <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            hsyncS1   <= hsync_in;
            vsyncS1   <= vsync_in;
            hsync_out <= hsyncS1;
            vsync_out <= vsyncS1;
        end
    end
endmodule

// File: tb/tb_pong_frame_renderer.sv
// tb/tb_pong_frame_renderer.sv - randomized model-checked bench for pong_frame_renderer
module tb_pong_frame_renderer;
    logic        VGA_CLK = 1'b0;
    logic        reset;
    logic [9:0]  hcount, vcount;
    logic        video_on, hsync_in, vsync_in;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out;

    pong_frame_renderer_if bus();

    pong_frame_renderer dut (
        .VGA_CLK   (VGA_CLK),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .gameBus   (bus),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int checks = 0;
    int errors = 0;

    // Reference state: the frame snapshot and what each output must show after each edge
    int mBx, mBy, mPx, mPy, mCx, mCy, mPs, mCs;
    logic [11:0] mS1, mRgb;
    logic mHs1, mHsOut, mVs1, mVsOut;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit inSpan(int p, int s, int n);
        return p >= s && p < s + n;
    endfunction

`ifdef SCORE_DISPLAY_EN
    function automatic bit glyphOn(int d, int c, int r);
        logic [14:0] g;
        if (c < 0 || c > 2 || r < 0 || r > 4) return 1'b0;
        if (d >= 10) return 1'b1;
        case (d)
            0: g = 15'b111_101_101_101_111;
            1: g = 15'b010_110_010_010_111;
            2: g = 15'b111_001_111_100_111;
            3: g = 15'b111_001_111_001_111;
            4: g = 15'b101_101_111_001_001;
            5: g = 15'b111_100_111_001_111;
            6: g = 15'b111_100_111_101_111;
            7: g = 15'b111_001_001_001_001;
            8: g = 15'b111_101_111_101_111;
            default: g = 15'b111_101_111_001_111;
        endcase
        return g[14 - (r * 3 + c)];
    endfunction
`endif

    function automatic logic [11:0] modelColor(int h, int v, bit von);
        int gx = h / 4;
        int gy = (v / 4) % 128;
        bit over = 1'b0;
        if (!von) return 12'h000;
`ifdef SCORE_DISPLAY_EN
        over = (mPs == 10) || (mCs == 10);
`endif
        if (!over && inSpan(gx, mBx, 4) && inSpan(gy, mBy, 4)) return 12'hFFF;
        if (inSpan(gx, mPx, 1) && inSpan(gy, mPy, 32)) return 12'h0F0;
        if (inSpan(gx, mCx, 1) && inSpan(gy, mCy, 32)) return 12'hF00;
`ifdef SCORE_DISPLAY_EN
        if (glyphOn(mPs, gx - 64, gy - 4) || glyphOn(mCs, gx - 93, gy - 4)) return 12'hFFF;
`endif
        if (gx == 80 && ((gy / 4) % 2) == 0) return 12'h888;
        return 12'h000;
    endfunction

    // One clock: check the tick, advance the reference across the edge, compare all outputs
    task automatic step();
        bit tick;
        #3;
        tick = (hcount == 10'd0) && (vcount == 10'd480) && !reset;
        check("frame_tick", 32'(bus.frame_tick), 32'(tick));
        @(posedge VGA_CLK);
        #1;
        if (reset) begin
            mRgb = 0; mS1 = 0; mHs1 = 0; mHsOut = 0; mVs1 = 0; mVsOut = 0;
            mBx = 80; mBy = 60; mPx = 3; mPy = 0; mCx = 156; mCy = 0; mPs = 0; mCs = 0;
        end else begin
            mRgb = mS1;
            mS1 = modelColor(int'(hcount), int'(vcount), video_on);
            mHsOut = mHs1; mHs1 = hsync_in;
            mVsOut = mVs1; mVs1 = vsync_in;
            if (tick) begin
                mBx = int'(bus.ballX_in);      mBy = int'(bus.ballY_in);
                mPx = int'(bus.playerXPos_in); mPy = int'(bus.playerYPos_in);
                mCx = int'(bus.comXPos_in);    mCy = int'(bus.comYPos_in);
                mPs = int'(bus.playerScore_in); mCs = int'(bus.comScore_in);
            end
        end
        check("rgb", 32'(rgb), 32'(mRgb));
        check("hsync_out", 32'(hsync_out), 32'(mHsOut));
        check("vsync_out", 32'(vsync_out), 32'(mVsOut));
    endtask

    task automatic setBus(int bx, int by, int px, int py, int cx, int cy, int ps, int cs);
        bus.ballX_in = 8'(bx);      bus.ballY_in = 7'(by);
        bus.playerXPos_in = 8'(px); bus.playerYPos_in = 7'(py);
        bus.comXPos_in = 8'(cx);    bus.comYPos_in = 7'(cy);
        bus.playerScore_in = 4'(ps); bus.comScore_in = 4'(cs);
    endtask

    task automatic randBus();
        setBus($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 255),
               $urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 127),
               ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 15),
               ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 15));
    endtask

    task automatic pix(int h, int v, bit von);
        reset = 1'b0;
        hcount = 10'(h);
        vcount = 10'(v);
        video_on = von;
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        step();
    endtask

    task automatic tick();
        pix(0, 480, 1'b0);
    endtask

    task automatic probe(input string name, int h, int v, logic [11:0] lit);
        pix(h, v, 1'b1);
        pix(2, 0, 1'b0);
        check(name, 32'(rgb), 32'(lit));
    endtask

    initial begin
        int h, v, sel;
        randBus();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hcount = 10'd0; vcount = 10'd480; video_on = 1'b1;
            hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            step();
        end
        check("reset_rgb", 32'(rgb), 32'h000);
        check("reset_tick", 32'(bus.frame_tick), 32'h0);
        check("reset_hsync", 32'(hsync_out), 32'h0);

        probe("ball_reset", 320, 240, 12'hFFF);
        probe("net", 320, 0, 12'h888);
        probe("player_reset", 12, 0, 12'h0F0);
        probe("com_reset", 624, 100, 12'hF00);
        probe("empty", 336, 240, 12'h000);

        setBus(80, 60, 3, 40, 156, 70, 0, 0);
        tick();
        setBus(10, 60, 3, 40, 156, 70, 0, 0);
        probe("ball_held", 320, 240, 12'hFFF);
        tick();
        probe("ball_moved", 40, 240, 12'hFFF);
        probe("ball_gone", 320, 240, 12'h000);

        setBus(156, 116, 3, 88, 156, 0, 0, 0);
        tick();
        probe("edge_right", 636, 476, 12'hFFF);
        probe("edge_nowrap", 0, 476, 12'h000);
        probe("paddle_bottom", 12, 476, 12'h0F0);
        probe("paddle_above", 12, 348, 12'h000);

        setBus(254, 126, 3, 0, 156, 0, 0, 0);
        tick();
        probe("nowrap_xy", 1020, 508, 12'hFFF);
        pix(1020, 508, 1'b0);
        pix(2, 0, 1'b0);
        check("blank", 32'(rgb), 32'h000);

        reset = 1'b1; hcount = 10'd100; vcount = 10'd100; video_on = 1'b1;
        step();
        probe("reset_snapshot", 320, 240, 12'hFFF);

`ifdef SCORE_DISPLAY_EN
        setBus(80, 60, 3, 0, 156, 0, 7, 10);
        tick();
        probe("digit7_top", 256, 16, 12'hFFF);
        probe("digit7_gap", 256, 20, 12'h000);
        probe("com_block", 376, 24, 12'hFFF);
        probe("ball_hidden", 320, 240, 12'h000);
`endif

        for (int f = 0; f < 40; f++) begin
            randBus();
            for (int p = 0; p < 150; p++) begin
                if ($urandom_range(0, 40) == 0) randBus();
                if ($urandom_range(0, 250) == 0) begin
                    reset = 1'b1; hcount = 10'($urandom); vcount = 10'($urandom);
                    video_on = 1'b1; hsync_in = 1'($urandom); vsync_in = 1'($urandom);
                    step();
                end
                sel = $urandom_range(0, 4);
                case (sel)
                    0: begin h = $urandom_range(0, 1023); v = $urandom_range(0, 1023); end
                    1: begin h = int'(bus.ballX_in) * 4 + $urandom_range(0, 23) - 4;
                             v = int'(bus.ballY_in) * 4 + $urandom_range(0, 23) - 4; end
                    2: begin h = int'(bus.playerXPos_in) * 4 + $urandom_range(0, 11) - 4;
                             v = int'(bus.playerYPos_in) * 4 + $urandom_range(0, 140) - 4; end
                    3: begin h = int'(bus.comXPos_in) * 4 + $urandom_range(0, 11) - 4;
                             v = int'(bus.comYPos_in) * 4 + $urandom_range(0, 140) - 4; end
                    default: begin h = $urandom_range(248, 392); v = $urandom_range(12, 40); end
                endcase
                h = h & 1023;
                v = v & 1023;
                if (h == 0 && v == 480) h = 1;
                pix(h, v, $urandom_range(0, 7) != 0);
            end
            if ($urandom_range(0, 7) == 0) pix(1, 480, 1'b0);
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
